// File: rtl/knowles32_pkg.sv
`default_nettype none
// ============================================================================
// knowles32_pkg: shared widths, LFSR polynomial, corner vectors and FSM states
// Revision: 1.0
// ============================================================================
package knowles32_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] LFSR_POLY = 32'h8020_0003;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
  } vec_t;

  localparam vec_t CORNER_0 = {32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
  localparam vec_t CORNER_1 = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
  localparam vec_t CORNER_2 = {32'h0000_0000, 32'h0000_0000, 1'b0};
  localparam vec_t CORNER_3 = {32'h8000_0000, 32'h8000_0000, 1'b0};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic vec_t corner_vec(input logic [1:0] idx);
    vec_t v;
    case (idx)
      2'd0:    v = CORNER_0;
      2'd1:    v = CORNER_1;
      2'd2:    v = CORNER_2;
      default: v = CORNER_3;
    endcase
    return v;
  endfunction

  // Right-shifting Galois form: the tap mask is the bit-reversed polynomial
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {1'b0, x[WIDTH-1:1]} ^ (x[0] ? LFSR_POLY : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/knowles32_lfsr.sv
`default_nettype none
// ============================================================================
// knowles32_lfsr: 32-bit Galois LFSR exposing one-step and two-step lookahead
// Revision: 1.0
// ============================================================================
module knowles32_lfsr
  import knowles32_pkg::*;
#(
  parameter logic [WIDTH-1:0] SEED = 32'd255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] next1,
  output logic [WIDTH-1:0] next2
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    next1   = lfsr_next(state_q);
    next2   = lfsr_next(next1);
    state_d = state_q;
    if (load) begin
      state_d = SEED_EFF;
    end else if (step) begin
      state_d = next2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/knowles32_bist.sv
`default_nettype none
// ============================================================================
// knowles32_bist: drives vectors into a 32-bit adder and checks S/Co against a
// behavioural sum. Define KNOWLES32_BIST_STOP_ON_FAIL_EN to stop at first error.
// Revision: 1.0
// ============================================================================
module knowles32_bist
  import knowles32_pkg::*;
#(
  parameter int               TRIALS        = 100000,
  parameter logic [WIDTH-1:0] SEED          = 32'd255,
  parameter int               SETTLE_CYCLES = 1,
  parameter int               CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] S,
  input  logic             Co,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Ci,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] trial_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_ci
);

  localparam logic [31:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic             ci_q, ci_d, fail_ci_q, fail_ci_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d, trial_q, trial_d;
  logic [31:0]      settle_q, settle_d;

  logic             lfsr_load, lfsr_step, go, mismatch, last_trial;
  logic [WIDTH-1:0] lfsr_n1, lfsr_n2;
  logic [WIDTH:0]   exp_sum;
  logic [CNT_W-1:0] trial_inc;

  knowles32_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .next1 (lfsr_n1),
    .next2 (lfsr_n2)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ci_d      = ci_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    trial_d   = trial_q;
    fail_a_d  = fail_a_q;
    fail_b_d  = fail_b_q;
    fail_ci_d = fail_ci_q;
    settle_d  = settle_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    exp_sum    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, ci_q};
    mismatch   = ({Co, S} != exp_sum);
    trial_inc  = trial_q + 1'b1;
    last_trial = (trial_inc == CNT_W'(TRIALS));
    // busy stays high through the cycle that publishes done, so a start there is dropped
    go = start && !busy_q && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      DRIVE: begin
        if (trial_q < CNT_W'(4)) begin
          {a_d, b_d, ci_d} = corner_vec(trial_q[1:0]);
        end else begin
          a_d       = lfsr_n1;
          b_d       = lfsr_n2;
          ci_d      = lfsr_n1[WIDTH-1];
          lfsr_step = 1'b1;
        end
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        trial_d = trial_inc;
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (err_q == '0) begin
            fail_a_d  = a_q;
            fail_b_d  = b_q;
            fail_ci_d = ci_q;
          end
        end
`ifdef KNOWLES32_BIST_STOP_ON_FAIL_EN
        state_d = (last_trial || mismatch) ? DONE : DRIVE;
`else
        state_d = last_trial ? DONE : DRIVE;
`endif
      end
      DONE: begin
        if (!done_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
      end
      default: ;
    endcase

    if (go) begin
      state_d   = DRIVE;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      err_d     = '0;
      trial_d   = '0;
      fail_a_d  = '0;
      fail_b_d  = '0;
      fail_ci_d = 1'b0;
      lfsr_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ci_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      trial_q   <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
      fail_ci_q <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ci_q      <= ci_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      trial_q   <= trial_d;
      fail_a_q  <= fail_a_d;
      fail_b_q  <= fail_b_d;
      fail_ci_q <= fail_ci_d;
      settle_q  <= settle_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign Ci          = ci_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign trial_count = trial_q;
  assign fail_a      = fail_a_q;
  assign fail_b      = fail_b_q;
  assign fail_ci     = fail_ci_q;

endmodule
`default_nettype wire

// File: tb/tb_knowles32_bist.sv
`default_nettype none
// ============================================================================
// tb_knowles32_bist: scoreboard bench with a fault-injectable adder model
// Revision: 1.0
// ============================================================================
module tb_knowles32_bist;

  localparam int          TRIALS = 12;
  localparam int          SETTLE = 1;
  localparam int          CNT_W  = 32;
  localparam int          PER    = SETTLE + 2;
  localparam logic [31:0] SEED   = 32'd255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      s_in;
  logic             co_in;
  logic [31:0]      a_out, b_out, fail_a, fail_b;
  logic             ci_out, busy, done, pass, fail_ci;
  logic [CNT_W-1:0] err_count, trial_count;

  knowles32_bist #(
    .TRIALS(TRIALS), .SEED(SEED), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .S(s_in), .Co(co_in),
    .A(a_out), .B(b_out), .Ci(ci_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .trial_count(trial_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_ci(fail_ci)
  );

  always #5 clk = ~clk;

  // Adder under test: true sum with an optional stuck-at fault (1: S bit, 2: Co)
  int   fault_kind = 0;
  int   fault_bit  = 0;
  logic fault_val  = 1'b0;
  logic [32:0] true_sum;
  always_comb begin
    true_sum = {1'b0, a_out} + {1'b0, b_out} + 33'(ci_out);
    s_in  = true_sum[31:0];
    co_in = true_sum[32];
    if (fault_kind == 1) s_in[fault_bit] = fault_val;
    if (fault_kind == 2) co_in = fault_val;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
  } vec_t;

  typedef struct {
    int          err;
    int          trials;
    logic        pass;
    logic [31:0] fa;
    logic [31:0] fb;
    logic        fci;
    int          done_edge;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   run_k = 0;
  bit   run_active = 1'b0;
  logic done_prev = 1'b0;
  vec_t vec_exp[$];
  res_t exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference model: whole-run outcome from the vector list and the fault rule
  task automatic build_run(input int kind, input int fb, input logic fv, output res_t r);
    logic [31:0] l;
    logic [32:0] t, o;
    vec_t        v;
    l = (SEED == 0) ? 32'd1 : SEED;
    r.err = 0; r.trials = 0; r.pass = 1'b0;
    r.fa = '0; r.fb = '0; r.fci = 1'b0; r.done_edge = 0;
    vec_exp.delete();
    for (int i = 0; i < TRIALS; i++) begin
      case (i)
        0: v = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        1: v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        2: v = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        3: v = '{32'h8000_0000, 32'h8000_0000, 1'b0};
        default: begin
          v.a = lfsr_step(l);
          v.b = lfsr_step(v.a);
          v.ci = v.a[31];
          l = v.b;
        end
      endcase
      vec_exp.push_back(v);
      t = {1'b0, v.a} + {1'b0, v.b} + 33'(v.ci);
      o = t;
      if (kind == 1) o[fb] = fv;
      if (kind == 2) o[32] = fv;
      r.trials++;
      if (o != t) begin
        if (r.err == 0) begin
          r.fa = v.a; r.fb = v.b; r.fci = v.ci;
        end
        r.err++;
`ifdef KNOWLES32_BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
  endtask

  // Vector monitor: trial n's vector appears after edge k+1+n*PER
  int vm_c, vm_i;
  always @(negedge clk) begin
    if (run_active) begin
      vm_c = edge_cnt - run_k;
      if (vm_c >= 1 && (vm_c - 1) % PER == 0) begin
        vm_i = (vm_c - 1) / PER;
        if (vm_i < vec_exp.size())
          chk($sformatf("vector[%0d]", vm_i), {a_out, b_out, ci_out},
              {vec_exp[vm_i].a, vec_exp[vm_i].b, vec_exp[vm_i].ci});
      end
    end
  end

  // Result monitor: pops one expectation on every rising done
  res_t er;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 96'(done), 96'(0));
      end else begin
        er = exp_q.pop_front();
        chk("done_edge",   96'(edge_cnt),    96'(er.done_edge));
        chk("err_count",   96'(err_count),   96'(er.err));
        chk("trial_count", 96'(trial_count), 96'(er.trials));
        chk("pass",        96'(pass),        96'(er.pass));
        chk("fail_vector", {fail_a, fail_b, fail_ci}, {er.fa, er.fb, er.fci});
      end
    end
    done_prev <= done;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_A"},     96'(a_out),       96'(0));
    chk({tag, "_B"},     96'(b_out),       96'(0));
    chk({tag, "_flags"}, 96'({ci_out, busy, done, pass, fail_ci}), 96'(0));
    chk({tag, "_err"},   96'(err_count),   96'(0));
    chk({tag, "_trial"}, 96'(trial_count), 96'(0));
    chk({tag, "_fail"},  {fail_a, fail_b}, 96'(0));
  endtask

  task automatic issue_start(input res_t r, input bit expect_done);
    res_t e;
    e = r;
    @(negedge clk);
    start = 1'b1;
    run_k = edge_cnt + 1;
    e.done_edge = run_k + 1 + r.trials * PER;
    if (expect_done) exp_q.push_back(e);
    run_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 96'({busy, done}), 96'(2'b10));
  endtask

  task automatic do_run(input int kind, input int fb, input logic fv, input bit poke);
    res_t r;
    int   waited;
    fault_kind = kind; fault_bit = fb; fault_val = fv;
    build_run(kind, fb, fv, r);
    issue_start(r, 1'b1);
    waited = 0;
    while (!done && waited < TRIALS * PER + 20) begin
      // Stray starts only while the run is certainly still busy
      if (poke && $urandom_range(0, 3) == 0 && edge_cnt + 1 < run_k + 1 + r.trials * PER)
        start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited++;
    end
    if (!done) chk("done_timeout", 96'(done), 96'(1));
    run_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   kind, fb;
    logic fv;
    res_t r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Directed fault scenarios first, then randomized ones
    do_run(0, 0, 1'b0, 1'b0);
    do_run(1, 0, 1'b0, 1'b0);
    do_run(2, 0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      kind = $urandom_range(0, 2);
      fb   = $urandom_range(0, 31);
      fv   = 1'($urandom_range(0, 1));
      do_run(kind, fb, fv, 1'($urandom_range(0, 1)));
    end

    // Abort a run during trial 5, then confirm a restart reproduces the vectors
    fault_kind = 0;
    build_run(0, 0, 1'b0, r);
    issue_start(r, 1'b0);
    while (edge_cnt < run_k + 1 + 5 * PER) @(negedge clk);
    run_active = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrun_reset");
    do_run(0, 0, 1'b0, 1'b1);

    chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/knowles32_bist.md
Name: knowles32_bist

Overview:
Synthesizable built-in self-test engine for the 32-bit Knowles adder. It is the driving and checking end of the adder interface.
- Generates operand vectors A, B, Ci into an external adder instance.
- Samples S and Co after a settle window and compares them against an internal behavioural 33-bit sum.
- Reports pass/fail, error count and the first failing vector.
- Sits beside the adder in silicon or FPGA bring-up builds; replaces the software random stimulus loop.

Parameters:
TRIALS, 100000, total vectors per run (includes corner vectors); must be >= 1
SEED, 255, LFSR seed; value 0 is replaced by 1
SETTLE_CYCLES, 1, idle cycles between driving a vector and sampling the result; >= 0
CNT_W, 32, width of trial and error counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse that begins a run
S  in  32  sum from adder under test
Co  in  1  carry-out from adder under test
A  out  32  operand A to adder
B  out  32  operand B to adder
Ci  out  1  carry-in to adder
busy  out  1  run in progress
done  out  1  run finished; held until next start or rst
pass  out  1  valid when done=1; 1 if err_count==0
err_count  out  CNT_W  mismatching trials; saturates at all-ones
trial_count  out  CNT_W  trials completed
fail_a  out  32  A of first failing trial
fail_b  out  32  B of first failing trial
fail_ci  out  1  Ci of first failing trial

Behaviour:
- Interface decision: one clock, clk; synchronous active-high reset, rst.
- Reset (any cycle, including mid-run):
  - All outputs go to 0.
  - State goes to IDLE.
  - LFSR reloads SEED (1 if SEED==0).
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: start=1 clears counters and fail_* and reloads the LFSR; next state DRIVE; busy=1 from that cycle.
- DRIVE (1 cycle): registers the next vector onto A/B/Ci.
  - Trials 0..3 are fixed corner vectors: (FFFFFFFF,00000000,1), (FFFFFFFF,FFFFFFFF,1), (00000000,00000000,0), (80000000,80000000,0). If TRIALS<4, only the first TRIALS of these are used.
  - Later trials: the LFSR advances twice. A = first step, B = second step, Ci = bit 31 of the first step.
  - LFSR is Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
- SETTLE: waits SETTLE_CYCLES cycles; skipped if 0.
- CHECK (1 cycle):
  - exp = {1'b0,A} + {1'b0,B} + Ci (33 bits).
  - Mismatch if S != exp[31:0] or Co != exp[32].
  - On mismatch: err_count increments (saturating). If it was 0, fail_a/fail_b/fail_ci capture A/B/Ci.
  - trial_count increments.
  - If trial_count reaches TRIALS, next state is DONE; otherwise DRIVE.
- Each trial takes SETTLE_CYCLES+2 cycles. With start sampled at edge k, done=1 is visible after edge k+1+TRIALS*(SETTLE_CYCLES+2).
- DONE: busy=0, done=1, pass=(err_count==0).
  - A/B/Ci hold the last vector.
  - start=1 restarts as from IDLE, clearing done.
- start while busy is ignored.
- Simultaneous rst and start: rst wins.

Optional Feature:
Macro KNOWLES32_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatching CHECK goes directly to DONE. That CHECK still updates err_count=1, trial_count and fail_*. pass=0.
- Undefined: the run always completes TRIALS trials and counts every error.

Decomposition:
- Package knowles32_pkg holds:
  - WIDTH=32
  - LFSR_POLY=32'h80200003
  - the four corner-vector constants
  - the state enum (IDLE, DRIVE, SETTLE, CHECK, DONE)
- Sub-module knowles32_lfsr: 32-bit Galois LFSR with load/seed and a step-enable. It outputs both the one-step and two-step next values so both can be consumed in one cycle.
- FSM, comparator and counters stay in the top.

Test Plan:
- Correct Knowles adder, TRIALS=6, SETTLE_CYCLES=1, start at edge 0 -> A/B/Ci sequence starts with FFFFFFFF/00000000/1; done=1 after edge 19; pass=1; err_count=0; trial_count=6.
- Adder model with S[0] stuck at 0, TRIALS=4 -> trial 0 has exp S=00000000 (match); trial 1 has exp S=FFFFFFFF (mismatch); fail_a=FFFFFFFF, fail_b=FFFFFFFF, fail_ci=1; pass=0.
- Adder model with Co tied 0, TRIALS=4 -> trials 0, 1 and 3 mismatch; err_count=3; fail_a=FFFFFFFF, fail_b=00000000, fail_ci=1.
- Same Co fault with KNOWLES32_BIST_STOP_ON_FAIL_EN defined -> done after trial 0 (edge 4 for SETTLE_CYCLES=1); err_count=1; trial_count=1.
- rst asserted during trial 5 of a 100-trial run -> next cycle all outputs are 0 and state is IDLE. A restart reproduces A/B exactly as in the first run, including trial 4's LFSR vector.
- start pulsed while busy=1 -> no effect; trial_count and done timing are unchanged versus an undisturbed run.
